fruit_engine: RTL

FRUIT_ENGINE -- requirements
Module: fruit_engine

---
 rtl/fruit_engine.sv | 96 +++++++++
 1 files changed

// File: rtl/fruit_engine.sv
// fruit_engine: falling-fruit catch game core with LFSR spawn column, paddle catch test and miss tracking.
module fruit_engine #(
  parameter int FRUIT_SIZE = 16,
  parameter int FALL_STEP = 2,
  parameter int PADDLE_TOP = 450,
  parameter int MAX_MISSES = 5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_tick_i,
  input  logic        start_i,
  input  logic [10:0] paddle_x_i,
  input  logic [10:0] current_x_i,
  input  logic [10:0] current_y_i,
  output logic        fruit_on_o,
  output logic [10:0] fruit_x_o,
  output logic [10:0] fruit_y_o,
  output logic [7:0]  score_o,
  output logic [3:0]  misses_o,
  output logic        game_over_o,
  output logic        catch_pulse_o
);
  typedef enum logic [1:0] {IDLE, SPAWN, FALL, OVER} state_t;
  localparam logic [11:0] FS = 12'(FRUIT_SIZE);
  localparam logic [11:0] HALF = 12'(FRUIT_SIZE / 2);
  localparam logic [11:0] MAX_X = 12'(640 - FRUIT_SIZE);
  localparam logic [11:0] PT = 12'(PADDLE_TOP);
  localparam logic [11:0] PT_END = 12'(PADDLE_TOP + 25);
  state_t      state_q;
  logic [7:0]  lfsr_q, lfsr_d, score_q;
  logic [10:0] fx_q, fy_q;
  logic [3:0]  misses_q, misses_d;
  logic        catch_pulse_q;
  logic [11:0] spawn_x, fx_end, fy_end, dx, adx;
  logic        tick_fall, y_hit, catch_hit, miss_hit;
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    spawn_x = {3'b000, lfsr_q, 1'b0} + 12'd32;
    spawn_x = (spawn_x > MAX_X) ? MAX_X : spawn_x;
    fx_end = {1'b0, fx_q} + FS;
    fy_end = {1'b0, fy_q} + FS;
    // Two's-complement distance between fruit centre and paddle centre
    dx = {1'b0, fx_q} + HALF - {1'b0, paddle_x_i};
    adx = dx[11] ? ~dx + 12'd1 : dx;
    tick_fall = (state_q == FALL) && frame_tick_i;
    y_hit = (fy_end >= PT) && ({1'b0, fy_q} < PT_END);
    catch_hit = tick_fall && y_hit && (adx < 12'd50);
    miss_hit = tick_fall && !catch_hit && (fy_q >= 11'd480);
    misses_d = misses_q + 4'd1;
    fruit_on_o = (state_q == FALL) &&
                 ({1'b0, current_x_i} >= {1'b0, fx_q}) && ({1'b0, current_x_i} < fx_end) &&
                 ({1'b0, current_y_i} >= {1'b0, fy_q}) && ({1'b0, current_y_i} < fy_end);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      fx_q <= '0;
      fy_q <= '0;
      score_q <= '0;
      misses_q <= '0;
      catch_pulse_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      catch_pulse_q <= catch_hit;
      case (state_q)
        IDLE, OVER: if (start_i) begin
          state_q <= SPAWN;
          score_q <= '0;
          misses_q <= '0;
        end
        SPAWN: begin
          fx_q <= spawn_x[10:0];
          fy_q <= '0;
          state_q <= FALL;
        end
        FALL: if (catch_hit) begin
          score_q <= (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          state_q <= SPAWN;
        end else if (miss_hit) begin
          misses_q <= misses_d;
          state_q <= (misses_d == 4'(MAX_MISSES)) ? OVER : SPAWN;
        end else if (frame_tick_i) begin
          fy_q <= fy_q + 11'(FALL_STEP);
        end
      endcase
    end
  end
  assign fruit_x_o = fx_q;
  assign fruit_y_o = fy_q;
  assign score_o = score_q;
  assign misses_o = misses_q;
  assign game_over_o = (state_q == OVER);
  assign catch_pulse_o = catch_pulse_q;
endmodule
